if_id_stage: RTL

//  IF/ID pipeline register plus field decode for the MIPS core. Captures fetched

---
 rtl/if_id_stage.sv | 77 +++++++
 1 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with field slicing, extender control and
// unsupported-opcode detection; supports stall, flush and bubble insertion.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    input  logic        valid_in,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] instr_q,
    output logic [31:0] pc4_q,
    output logic        valid_q,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic        extcon,
    output logic        illegal_q
);
    logic [31:0] instr_d, pc4_d;
    logic        valid_d, extcon_d, extcon_q, illegal_d;
    logic [5:0]  op_in;
    logic        supported, ext_in, bubble;

    assign op_in = instr_in[31:26];
    // andi/ori/xori/lui (0x0C-0x0F) are the only zero-extending immediates
    assign ext_in = op_in[5:2] != 4'b0011;
    assign bubble = flush || (!stall && !valid_in);

    always_comb begin
        supported = 1'b0;
        case (op_in)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: supported = 1'b1;
            default: supported = 1'b0;
        endcase
    end

    always_comb begin
        instr_d   = bubble ? 32'h0 : stall ? instr_q : instr_in;
        pc4_d     = stall && !flush ? pc4_q : pc4_in;
        valid_d   = bubble ? 1'b0 : stall ? valid_q : 1'b1;
        extcon_d  = bubble ? 1'b1 : stall ? extcon_q : ext_in;
        illegal_d = bubble ? 1'b0 : stall ? illegal_q : !supported;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q   <= 32'h0;
            pc4_q     <= RESET_PC;
            valid_q   <= 1'b0;
            extcon_q  <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc4_q     <= pc4_d;
            valid_q   <= valid_d;
            extcon_q  <= extcon_d;
            illegal_q <= illegal_d;
        end
    end

    assign extcon = extcon_q;
    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign shamt  = instr_q[10:6];
    assign funct  = instr_q[5:0];
    assign imm16  = instr_q[15:0];
endmodule
